t_clkq_sequencer: RTL and testbench

T_CLKQ_SEQUENCER -- requirements
Module: t_clkq_sequencer

---
 rtl/t_clkq_sequencer.sv | 138 +++++++++++++
 tb/tb_t_clkq_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/t_clkq_sequencer.sv
// rtl/t_clkq_sequencer.sv - sample sequencer: runs 2**LOG2_SAMPLES measurements and reports mean/min/max
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   req         run request, honoured only while idle
//   busy        high whenever a run is in progress or its result is pending
//   meas_start  one-cycle start pulse to the measurement stage
//   meas_cnt    measured count, 0 while the measurement stage is still measuring
//   res_valid   result valid (DONE)
//   res_ready   consumer accepts the result
//   res_avg     truncated mean of the run's samples
//   res_min     minimum sample of the run
//   res_max     maximum sample of the run
//   res_timeout run aborted because a sample never arrived
module t_clkq_sequencer #(
    parameter int CNT_WIDTH    = 8,
    parameter int LOG2_SAMPLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    output logic                 busy,
    output logic                 meas_start,
    input  logic [CNT_WIDTH-1:0] meas_cnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CNT_WIDTH-1:0] res_avg,
    output logic [CNT_WIDTH-1:0] res_min,
    output logic [CNT_WIDTH-1:0] res_max,
    output logic                 res_timeout
);

    localparam int SUM_W  = CNT_WIDTH + LOG2_SAMPLES;
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int SCNT_W = LOG2_SAMPLES + 1;

    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << LOG2_SAMPLES) - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [SCNT_W-1:0]    samp_cnt;
    logic [SUM_W-1:0]     sum;
    logic [CNT_WIDTH-1:0] run_min;
    logic [CNT_WIDTH-1:0] run_max;

    logic                 capture;
    logic                 timed_out;
    logic [SUM_W-1:0]     sum_next;
    logic [CNT_WIDTH-1:0] min_next;
    logic [CNT_WIDTH-1:0] max_next;
    logic [CNT_WIDTH-1:0] avg_next;

    assign busy       = (state != S_IDLE);
    assign meas_start = (state == S_START);
    assign res_valid  = (state == S_DONE);

    // A nonzero count wins over the timeout on the cycle the limit is reached.
    assign capture   = (state == S_WAIT) && (meas_cnt != '0);
    assign timed_out = (state == S_WAIT) && (meas_cnt == '0) && (wait_cnt == WAIT_LIMIT);

    // Statistics including the sample being captured this cycle, so the final
    // capture can load the result registers directly.
    assign sum_next = sum + SUM_W'(meas_cnt);
    assign min_next = (meas_cnt < run_min) ? meas_cnt : run_min;
    assign max_next = (meas_cnt > run_max) ? meas_cnt : run_max;
    assign avg_next = CNT_WIDTH'(sum_next >> LOG2_SAMPLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            samp_cnt    <= '0;
            sum         <= '0;
            run_min     <= '0;
            run_max     <= '0;
            res_avg     <= '0;
            res_min     <= '0;
            res_max     <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state    <= S_START;
                        sum      <= '0;
                        samp_cnt <= '0;
                        run_min  <= '1;
                        run_max  <= '0;
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        sum     <= sum_next;
                        run_min <= min_next;
                        run_max <= max_next;
                        if (samp_cnt == LAST_SAMPLE) begin
                            state       <= S_DONE;
                            res_avg     <= avg_next;
                            res_min     <= min_next;
                            res_max     <= max_next;
                            res_timeout <= 1'b0;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                            state    <= S_START;
                        end
                    end else if (timed_out) begin
                        state       <= S_DONE;
                        res_avg     <= '0;
                        res_min     <= '0;
                        res_max     <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t_clkq_sequencer.sv
// tb/tb_t_clkq_sequencer.sv - self-checking bench for t_clkq_sequencer
module tb_t_clkq_sequencer;

    localparam int TIMEOUT = 255;
    localparam int NS      = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       busy;
    logic       meas_start;
    logic [7:0] meas_cnt = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_avg;
    logic [7:0] res_min;
    logic [7:0] res_max;
    logic       res_timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Stub configuration: per-sample value and return delay in WAIT cycles (0 = never returns).
    int vals [NS];
    int dlys [NS];

    t_clkq_sequencer #(
        .CNT_WIDTH   (8),
        .LOG2_SAMPLES(2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .busy       (busy),
        .meas_start (meas_start),
        .meas_cnt   (meas_cnt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_avg    (res_avg),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    // Measurement stub: returns vals[i] on the dlys[i]-th cycle after its start pulse.
    int stub_idx = 0;
    int stub_cur = 0;
    int stub_cyc = 0;
    always @(negedge clk) begin
        if (!busy) begin
            stub_idx = 0;
            meas_cnt = 8'd0;
        end else if (meas_start) begin
            stub_cur = stub_idx;
            stub_idx = stub_idx + 1;
            stub_cyc = 0;
            meas_cnt = 8'd0;
        end else if (!res_valid) begin
            stub_cyc = stub_cyc + 1;
            if (stub_cur < NS && dlys[stub_cur] != 0 && stub_cyc == dlys[stub_cur])
                meas_cnt = 8'(vals[stub_cur]);
            else
                meas_cnt = 8'd0;
        end else begin
            meas_cnt = 8'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full run against the reference model: latency, pulse count, results,
    // stability under back-pressure, then return to idle with retained results.
    task automatic do_run(input string tag, input int hold, input bit extra_req);
        int     exp_lat, exp_pulses, s, mn, mx, n, pulses;
        bit     eto;
        logic [7:0] ea, emn, emx;
        eto = 0; exp_lat = 0; exp_pulses = NS; s = 0; mn = 255; mx = 0;
        for (int i = 0; i < NS; i++) begin
            if (dlys[i] == 0) begin
                eto = 1;
                exp_pulses = i + 1;
                exp_lat += 1 + TIMEOUT + 1;
                break;
            end
            exp_lat += dlys[i] + 1;
            s += vals[i];
            if (vals[i] < mn) mn = vals[i];
            if (vals[i] > mx) mx = vals[i];
        end
        ea  = eto ? 8'd0 : 8'(s / NS);
        emn = eto ? 8'd0 : 8'(mn);
        emx = eto ? 8'd0 : 8'(mx);

        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 0; pulses = 0;
        while (!res_valid && n < 3000) begin
            pulses += int'(meas_start);
            req = extra_req && (n == 2 || n == 5);
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        check({tag, " valid"},   32'(res_valid), 32'd1);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " pulses"},  pulses, exp_pulses);
        check({tag, " avg"},     32'(res_avg), 32'(ea));
        check({tag, " min"},     32'(res_min), 32'(emn));
        check({tag, " max"},     32'(res_max), 32'(emx));
        check({tag, " timeout"}, 32'(res_timeout), 32'(eto));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold"}, {res_valid, res_timeout, res_avg, res_min, res_max},
                  {1'b1, eto, ea, emn, emx});
        end
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        check({tag, " idle"},     {busy, res_valid}, 32'd0);
        check({tag, " retained"}, {res_timeout, res_avg, res_min, res_max}, {eto, ea, emn, emx});
        @(negedge clk);
        check({tag, " no queued run"}, {busy, meas_start}, 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NS; i++) begin vals[i] = 1; dlys[i] = 1; end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs", {busy, meas_start, res_valid, res_timeout, res_avg, res_min, res_max}, 32'd0);
        rst = 1'b0;

        // Reference sample sequence
        vals = '{40, 42, 41, 45};
        dlys = '{1, 3, 2, 1};
        do_run("basic", 0, 0);

        // Back-pressure with result held
        vals = '{10, 200, 7, 99};
        dlys = '{2, 1, 4, 2};
        do_run("backpressure", 10, 0);

        // Saturated samples
        vals = '{255, 255, 255, 255};
        dlys = '{1, 1, 1, 1};
        do_run("allmax", 0, 0);

        // Random runs, with req pulses during busy on some
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NS; i++) begin
                vals[i] = $urandom_range(1, 255);
                dlys[i] = $urandom_range(1, 6);
            end
            do_run("random", $urandom_range(0, 3), r[0]);
        end

        // Timeout on first sample, then on a later one
        vals = '{5, 6, 7, 8};
        dlys = '{0, 1, 1, 1};
        do_run("timeout first", 2, 0);
        dlys = '{1, 2, 0, 1};
        do_run("timeout third", 0, 0);

        // Capture on the very cycle the limit is reached
        vals = '{9, 9, 9, 12};
        dlys = '{TIMEOUT + 1, 1, 1, 1};
        do_run("capture at limit", 0, 0);

        // Reset during the third sample's wait
        vals = '{100, 100, 100, 100};
        dlys = '{3, 3, 3, 3};
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 0;
        while (!(stub_idx == 3 && busy && !meas_start) && n < 100) begin @(negedge clk); n++; end
        check("reach third wait", 32'(n < 100), 32'd1);
        rst = 1'b1; req = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 1'b0; res_ready = 1'b0;
        check("mid-run reset", {busy, meas_start, res_valid, res_timeout, res_avg, res_min, res_max}, 32'd0);
        vals = '{3, 4, 5, 6};
        dlys = '{1, 2, 1, 2};
        do_run("after reset", 0, 0);

        // req held high: back-to-back runs separated by an idle cycle
        vals = '{20, 30, 40, 50};
        dlys = '{1, 1, 1, 1};
        @(negedge clk); req = 1'b1;
        n = 0;
        while (!res_valid && n < 200) begin @(negedge clk); n++; end
        check("held req done", 32'(res_valid), 32'd1);
        check("held req avg", 32'(res_avg), 32'd35);
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        check("held req idle gap", 32'(busy), 32'd0);
        @(negedge clk); req = 1'b0;
        check("held req restart", 32'(meas_start), 32'd1);
        n = 0;
        while (!res_valid && n < 200) begin @(negedge clk); n++; end
        check("held req second run", {res_valid, res_min, res_max}, {1'b1, 8'd20, 8'd50});
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        check("held req final idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
